// File: rtl/sdr_toggle_responder_if.sv
// SDRAM controller command port seen from the toggle responder.
// The responder uses the master side and the controller uses the slave side.
interface sdr_toggle_responder_if #(
  parameter int MEM_AW = 24
);
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_we;
  logic              mem_burst2;
  logic              mem_start;
  logic              mem_rdy;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;
  logic              mem_wdone;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_we, mem_burst2, mem_start,
    input  mem_rdy, mem_rvalid, mem_rdata, mem_wdone
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_burst2, mem_start,
    output mem_rdy, mem_rvalid, mem_rdata, mem_wdone
  );
endinterface

// File: rtl/sdr_toggle_responder.sv
// Serves the CPU (16-bit read/write) and SCN (32-bit read-only) toggle-handshake channels
// over a single SDRAM command port. It alternates between the two channels when both are waiting.
module sdr_toggle_responder #(
  parameter int MEM_AW = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   cpu_addr,
  input  logic [15:0]                   cpu_data,
  input  logic [1:0]                    cpu_be,
  input  logic                          cpu_rw,
  input  logic                          cpu_req,
  output logic                          cpu_ack,
  output logic [15:0]                   cpu_q,
  input  logic [31:0]                   scn_addr,
  input  logic                          scn_req,
  output logic                          scn_ack,
  output logic [31:0]                   scn_q,
  sdr_toggle_responder_if.master        mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, WDONE} state_t;

  state_t state;
  logic   beat_cnt;
  logic   last_scn;
  logic   cpu_pend;
  logic   scn_pend;
  logic   pick_scn;
  logic   unused_addr_bits;

  assign cpu_pend = cpu_req ^ cpu_ack;
  assign scn_pend = scn_req ^ scn_ack;

  // On a tie, the channel that was not served last wins. last_scn also identifies the channel in flight.
  assign pick_scn = scn_pend & (~cpu_pend | ~last_scn);

  assign unused_addr_bits = ^{cpu_addr[31:MEM_AW+1], cpu_addr[0],
                              scn_addr[31:MEM_AW+1], scn_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      beat_cnt       <= 1'b0;
      last_scn       <= 1'b0;
      cpu_ack        <= 1'b0;
      scn_ack        <= 1'b0;
      cpu_q          <= '0;
      scn_q          <= '0;
      mem.mem_start  <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_burst2 <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      mem.mem_be     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_pend | scn_pend) begin
            state         <= ISSUE;
            mem.mem_start <= 1'b1;
            last_scn      <= pick_scn;
            if (pick_scn) begin
              mem.mem_addr   <= {scn_addr[MEM_AW:2], 1'b0};
              mem.mem_be     <= 2'b11;
              mem.mem_we     <= 1'b0;
              mem.mem_burst2 <= 1'b1;
            end else begin
              mem.mem_addr   <= cpu_addr[MEM_AW:1];
              mem.mem_be     <= cpu_be;
              mem.mem_we     <= ~cpu_rw;
              mem.mem_wdata  <= cpu_data;
              mem.mem_burst2 <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (mem.mem_rdy) begin
            mem.mem_start <= 1'b0;
            beat_cnt      <= 1'b0;
            state         <= mem.mem_we ? WDONE : RDATA;
          end
        end

        // An SCN burst fills the low half first. The ack toggles on the edge that captures the final beat.
        RDATA: begin
          if (mem.mem_rvalid) begin
            if (last_scn) begin
              if (!beat_cnt) begin
                scn_q[15:0] <= mem.mem_rdata;
                beat_cnt    <= 1'b1;
              end else begin
                scn_q[31:16] <= mem.mem_rdata;
                scn_ack      <= ~scn_ack;
                state        <= IDLE;
              end
            end else begin
              cpu_q   <= mem.mem_rdata;
              cpu_ack <= ~cpu_ack;
              state   <= IDLE;
            end
          end
        end

        WDONE: begin
          if (mem.mem_wdone) begin
            cpu_ack <= ~cpu_ack;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_toggle_responder.sv
// Self-checking bench for sdr_toggle_responder. It plays both requesters and the SDRAM controller, then
// checks fixed vectors, corner sequences, and random traffic against a transaction-level model.
module tb_sdr_toggle_responder;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [15:0] cpu_data;
  logic [1:0]  cpu_be;
  logic        cpu_rw;
  logic        cpu_req;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic [31:0] scn_addr;
  logic        scn_req;
  logic        scn_ack;
  logic [31:0] scn_q;

  int checks   = 0;
  int failures = 0;

  sdr_toggle_responder_if #(.MEM_AW(24)) mem_if ();

  sdr_toggle_responder #(.MEM_AW(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_be   (cpu_be),
    .cpu_rw   (cpu_rw),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack),
    .cpu_q    (cpu_q),
    .scn_addr (scn_addr),
    .scn_req  (scn_req),
    .scn_ack  (scn_ack),
    .scn_q    (scn_q),
    .mem      (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        is_scn;
    logic        rw;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] b0;
    logic [15:0] b1;
    int          rdy_delay;
    int          gap;
    logic [23:0] exp_addr;
    logic        exp_burst;
    logic        exp_we;
    logic [1:0]  exp_be;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs [6];

  // Transaction-level model: acks, held read data, outstanding requests and the last channel served.
  logic        m_cpu_ack, m_scn_ack, m_last_scn, m_cpu_pend, m_scn_pend;
  logic [15:0] m_cpu_q;
  logic [31:0] m_scn_q;
  logic [31:0] m_cpu_addr, m_scn_addr;
  logic [15:0] m_cpu_data;
  logic [1:0]  m_cpu_be;
  logic        m_cpu_rw;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cpu_ack = 0; m_scn_ack = 0; m_last_scn = 0; m_cpu_pend = 0; m_scn_pend = 0;
    m_cpu_q = 0; m_scn_q = 0;
  endtask

  task automatic check_reset_values();
    checkOutput("rst_cpu_ack", 32'(cpu_ack), 0);
    checkOutput("rst_scn_ack", 32'(scn_ack), 0);
    checkOutput("rst_cpu_q", 32'(cpu_q), 0);
    checkOutput("rst_scn_q", scn_q, 0);
    checkOutput("rst_mem_start", 32'(mem_if.mem_start), 0);
    checkOutput("rst_mem_we", 32'(mem_if.mem_we), 0);
    checkOutput("rst_mem_burst2", 32'(mem_if.mem_burst2), 0);
    checkOutput("rst_mem_addr", 32'(mem_if.mem_addr), 0);
    checkOutput("rst_mem_wdata", 32'(mem_if.mem_wdata), 0);
    checkOutput("rst_mem_be", 32'(mem_if.mem_be), 0);
  endtask

  task automatic post_cpu(input logic rw, input logic [31:0] addr, input logic [15:0] data,
                          input logic [1:0] be);
    cpu_rw = rw; cpu_addr = addr; cpu_data = data; cpu_be = be;
    cpu_req = ~cpu_req;
    m_cpu_pend = 1; m_cpu_rw = rw; m_cpu_addr = addr; m_cpu_data = data; m_cpu_be = be;
  endtask

  task automatic post_scn(input logic [31:0] addr);
    scn_addr = addr;
    scn_req = ~scn_req;
    m_scn_pend = 1; m_scn_addr = addr;
  endtask

  // Acts as the controller for one transaction, starting from the negedge just after the request is posted.
  task automatic serve_one(input vec_t v);
    int n;
    n = 0;
    while (mem_if.mem_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_to_start_cycles", 32'(n), 1);
    if (mem_if.mem_start !== 1'b1) return;
    checkOutput("mem_addr", 32'(mem_if.mem_addr), 32'(v.exp_addr));
    checkOutput("mem_burst2", 32'(mem_if.mem_burst2), 32'(v.exp_burst));
    checkOutput("mem_we", 32'(mem_if.mem_we), 32'(v.exp_we));
    checkOutput("mem_be", 32'(mem_if.mem_be), 32'(v.exp_be));
    if (v.exp_we) checkOutput("mem_wdata", 32'(mem_if.mem_wdata), 32'(v.wdata));
    // Command fields must not follow the requester inputs once the command has been issued.
    if (v.is_scn) scn_addr = $urandom;
    else begin
      cpu_addr = $urandom; cpu_data = 16'($urandom); cpu_be = 2'($urandom); cpu_rw = 1'($urandom);
    end
    for (int i = 0; i < v.rdy_delay; i++) begin
      checkOutput("start_hold", 32'(mem_if.mem_start), 1);
      @(negedge clk);
    end
    checkOutput("start_hold", 32'(mem_if.mem_start), 1);
    checkOutput("addr_hold", 32'(mem_if.mem_addr), 32'(v.exp_addr));
    mem_if.mem_rdy = 1'b1;
    @(negedge clk);
    mem_if.mem_rdy = 1'b0;
    checkOutput("start_drop", 32'(mem_if.mem_start), 0);
    if (!v.exp_we) begin
      for (int b = 0; b < (v.is_scn ? 2 : 1); b++) begin
        for (int g = 0; g < v.gap; g++) @(negedge clk);
        checkOutput("cpu_ack_early", 32'(cpu_ack), 32'(m_cpu_ack));
        checkOutput("scn_ack_early", 32'(scn_ack), 32'(m_scn_ack));
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = (b == 0) ? v.b0 : v.b1;
        @(negedge clk);
        mem_if.mem_rvalid = 1'b0;
      end
    end else begin
      for (int g = 0; g < v.gap; g++) @(negedge clk);
      checkOutput("cpu_ack_early", 32'(cpu_ack), 32'(m_cpu_ack));
      mem_if.mem_wdone = 1'b1;
      @(negedge clk);
      mem_if.mem_wdone = 1'b0;
    end
    if (v.is_scn) begin
      m_scn_ack = ~m_scn_ack; m_scn_q = v.exp_q; m_scn_pend = 0;
    end else begin
      m_cpu_ack = ~m_cpu_ack; m_cpu_pend = 0;
      if (!v.exp_we) m_cpu_q = v.exp_q[15:0];
    end
    m_last_scn = v.is_scn;
    checkOutput("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
    checkOutput("scn_ack", 32'(scn_ack), 32'(m_scn_ack));
    checkOutput("cpu_q", 32'(cpu_q), 32'(m_cpu_q));
    checkOutput("scn_q", scn_q, m_scn_q);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_scn) post_scn(v.addr);
    else post_cpu(v.rw, v.addr, v.wdata, v.be);
    serve_one(v);
  endtask

  // Predict the next command from outstanding requests, then serve it with random controller timing.
  task automatic serve_model();
    vec_t v;
    v.is_scn    = m_scn_pend && (!m_cpu_pend || !m_last_scn);
    v.b0        = 16'($urandom);
    v.b1        = 16'($urandom);
    v.rdy_delay = int'($urandom_range(0, 3));
    v.gap       = int'($urandom_range(0, 3));
    if (v.is_scn) begin
      v.rw = 1; v.addr = m_scn_addr; v.wdata = 0; v.be = 2'b11;
      v.exp_addr  = 24'(((m_scn_addr % 32'h0200_0000) / 4) * 2);
      v.exp_burst = 1; v.exp_we = 0; v.exp_be = 2'b11;
      v.exp_q     = 32'(v.b1) * 32'h1_0000 + 32'(v.b0);
    end else begin
      v.rw = m_cpu_rw; v.addr = m_cpu_addr; v.wdata = m_cpu_data; v.be = m_cpu_be;
      v.exp_addr  = 24'((m_cpu_addr % 32'h0200_0000) / 2);
      v.exp_burst = 0; v.exp_we = !m_cpu_rw; v.exp_be = m_cpu_be;
      v.exp_q     = 32'(v.b0);
    end
    serve_one(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; scn_req = 1'b0;
    mem_if.mem_rdy = 0; mem_if.mem_rvalid = 0; mem_if.mem_wdone = 0; mem_if.mem_rdata = 0;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    vecs[0] = '{0, 1, 32'h0010_0004, 16'h0000, 2'b11, 16'hBEEF, 16'h0000, 0, 0, 24'h080002, 0, 0, 2'b11, 32'h0000_BEEF};
    vecs[1] = '{0, 0, 32'h0000_0020, 16'h12AB, 2'b10, 16'h0000, 16'h0000, 5, 3, 24'h000010, 0, 1, 2'b10, 32'h0};
    vecs[2] = '{1, 1, 32'h0000_0106, 16'h0000, 2'b00, 16'h1111, 16'h2222, 0, 3, 24'h000082, 1, 0, 2'b11, 32'h2222_1111};
    vecs[3] = '{0, 0, 32'h00FF_FFFF, 16'h5555, 2'b00, 16'h0000, 16'h0000, 1, 0, 24'h7FFFFF, 0, 1, 2'b00, 32'h0};
    vecs[4] = '{1, 1, 32'hFF00_0003, 16'h0000, 2'b00, 16'hA5A5, 16'h5A5A, 2, 1, 24'h800000, 1, 0, 2'b11, 32'h5A5A_A5A5};
    vecs[5] = '{0, 1, 32'hFFFF_FFFF, 16'h0000, 2'b01, 16'h0001, 16'h0000, 2, 0, 24'hFFFFFF, 0, 0, 2'b01, 32'h0000_0001};

    cpu_addr = 0; cpu_data = 0; cpu_be = 0; cpu_rw = 0; scn_addr = 0;
    do_reset();

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // Both channels pending together from reset: SCN first, then CPU, and the same order again.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      post_cpu(1'b1, 32'h0000_1000 + 32'(r), 16'h0, 2'b11);
      post_scn(32'h0000_2000 + 32'(4 * r));
      serve_model();
      checkOutput("tie_first_scn_ack", 32'(scn_ack), 32'((r + 1) % 2));
      checkOutput("tie_cpu_still_waiting", 32'(cpu_ack), 32'(r % 2));
      serve_model();
    end

    for (int it = 0; it < 40; it++) begin
      if (!m_cpu_pend && $urandom_range(0, 1) == 1)
        post_cpu(1'($urandom), $urandom, 16'($urandom), 2'($urandom));
      if (!m_scn_pend && $urandom_range(0, 1) == 1)
        post_scn($urandom);
      if (!m_cpu_pend && !m_scn_pend)
        post_cpu(1'($urandom), $urandom, 16'($urandom), 2'($urandom));
      serve_model();
    end
    while (m_cpu_pend || m_scn_pend) serve_model();

    // Stray beats and write completions while idle must be ignored.
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 16'hDEAD; mem_if.mem_wdone = 1'b1;
    repeat (2) @(negedge clk);
    mem_if.mem_rvalid = 1'b0; mem_if.mem_wdone = 1'b0;
    checkOutput("stray_cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
    checkOutput("stray_scn_ack", 32'(scn_ack), 32'(m_scn_ack));
    checkOutput("stray_cpu_q", 32'(cpu_q), 32'(m_cpu_q));
    checkOutput("stray_scn_q", scn_q, m_scn_q);
    checkOutput("stray_no_start", 32'(mem_if.mem_start), 0);

    // Reset in the middle of an SCN burst, after its first beat.
    post_scn(32'h0000_0200);
    @(negedge clk);
    checkOutput("mid_start", 32'(mem_if.mem_start), 1);
    mem_if.mem_rdy = 1'b1;
    @(negedge clk);
    mem_if.mem_rdy = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 16'h7777;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    reset = 1'b1; cpu_req = 1'b0; scn_req = 1'b0;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    model_clear();
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 16'h8888;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late_beat_scn_q", scn_q, 0);
    checkOutput("late_beat_scn_ack", 32'(scn_ack), 0);
    checkOutput("late_beat_no_start", 32'(mem_if.mem_start), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
